// File: rtl/muldiv_unit_if.sv
// Handshake and HI/LO bus between the pipeline and the iterative multiply/divide unit.
interface muldiv_unit_if #(
  parameter int unsigned XLEN = 32
);
  logic            start;
  logic [1:0]      op;
  logic [XLEN-1:0] src_a;
  logic [XLEN-1:0] src_b;
  logic            hold;
  logic            hi_we;
  logic            lo_we;
  logic [XLEN-1:0] wdata;
  logic            busy;
  logic            done;
  logic [XLEN-1:0] hi;
  logic [XLEN-1:0] lo;
  logic            div_by_zero;

  modport master (
    output start, op, src_a, src_b, hold, hi_we, lo_we, wdata,
    input  busy, done, hi, lo, div_by_zero
  );

  modport slave (
    input  start, op, src_a, src_b, hold, hi_we, lo_we, wdata,
    output busy, done, hi, lo, div_by_zero
  );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative 32-bit MULT/MULTU/DIV/DIVU unit: sign-magnitude prep, 32 shift-add or
// restoring-divide steps, sign fix-up, result into architectural HI/LO.
module muldiv_unit #(
  parameter int unsigned XLEN = 32
) (
  input  logic          clk,
  input  logic          rst,
  muldiv_unit_if.slave  bus
);

  localparam int unsigned CW = $clog2(XLEN);
  localparam logic [CW-1:0] LAST = CW'(XLEN - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_PREP,
    S_RUN,
    S_FIX,
    S_DONE
  } state_e;

  state_e            state_q, state_d;
  logic [1:0]        op_q, op_d;
  logic [XLEN-1:0]   opa_q, opa_d;
  logic [XLEN-1:0]   opb_q, opb_d;
  logic [XLEN-1:0]   dvs_q, dvs_d;
  logic [2*XLEN-1:0] acc_q, acc_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              sa_q, sa_d;
  logic              sb_q, sb_d;
  logic [XLEN-1:0]   hi_q, hi_d;
  logic [XLEN-1:0]   lo_q, lo_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              dbz_q, dbz_d;

  logic              is_div;
  logic              is_signed;
  logic [XLEN-1:0]   mag_a;
  logic [XLEN-1:0]   mag_b;
  logic [XLEN:0]     mul_sum;
  logic [2*XLEN-1:0] mul_next;
  logic [XLEN:0]     div_hi;
  logic [XLEN:0]     div_diff;
  logic              div_ge;
  logic [2*XLEN-1:0] div_next;

  assign is_div    = op_q[1];
  assign is_signed = ~op_q[0];
  assign mag_a     = (is_signed && opa_q[XLEN-1]) ? -opa_q : opa_q;
  assign mag_b     = (is_signed && opb_q[XLEN-1]) ? -opb_q : opb_q;

  // Multiply: acc = {partial product, remaining multiplier bits}; add then shift right.
  assign mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, dvs_q} : '0);
  assign mul_next = {mul_sum, acc_q[XLEN-1:1]};

  // Divide: acc = {remainder, dividend/quotient}; shift left, trial subtract, restore.
  assign div_hi   = acc_q[2*XLEN-1:XLEN-1];
  assign div_diff = div_hi - {1'b0, dvs_q};
  assign div_ge   = ~div_diff[XLEN];
  assign div_next = {(div_ge ? div_diff[XLEN-1:0] : div_hi[XLEN-1:0]),
                     acc_q[XLEN-2:0], div_ge};

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      op_q    <= '0;
      opa_q   <= '0;
      opb_q   <= '0;
      dvs_q   <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      sa_q    <= 1'b0;
      sb_q    <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      opa_q   <= opa_d;
      opb_q   <= opb_d;
      dvs_q   <= dvs_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      sa_q    <= sa_d;
      sb_q    <= sb_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      dbz_q   <= dbz_d;
    end
  end

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    opa_d   = opa_q;
    opb_d   = opb_q;
    dvs_d   = dvs_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    sa_d    = sa_q;
    sb_d    = sb_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    busy_d  = busy_q;
    done_d  = done_q;
    dbz_d   = dbz_q;

    if (!bus.hold) begin
      if (!busy_q) begin
        if (bus.hi_we) hi_d = bus.wdata;
        if (bus.lo_we) lo_d = bus.wdata;
      end

      unique case (state_q)
        S_IDLE: begin
          if (bus.start) begin
            op_d    = bus.op;
            opa_d   = bus.src_a;
            opb_d   = bus.src_b;
            dbz_d   = 1'b0;
            state_d = S_PREP;
          end
        end
        S_PREP: begin
          sa_d  = is_signed & opa_q[XLEN-1];
          sb_d  = is_signed & opb_q[XLEN-1];
          cnt_d = '0;
          if (is_div) begin
            dvs_d = mag_b;
            acc_d = {{XLEN{1'b0}}, mag_a};
          end else begin
            dvs_d = mag_a;
            acc_d = {{XLEN{1'b0}}, mag_b};
          end
          state_d = S_RUN;
        end
        S_RUN: begin
          acc_d = is_div ? div_next : mul_next;
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == LAST) state_d = S_FIX;
        end
        S_FIX: begin
          if (is_div) begin
            // Zero divisor bypasses the datapath result: all-ones quotient, raw dividend.
            if (opb_q == '0) begin
              lo_d  = '1;
              hi_d  = opa_q;
              dbz_d = 1'b1;
            end else begin
              lo_d = (sa_q ^ sb_q) ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
              hi_d = sa_q ? -acc_q[2*XLEN-1:XLEN] : acc_q[2*XLEN-1:XLEN];
            end
          end else begin
            {hi_d, lo_d} = (sa_q ^ sb_q) ? -acc_q : acc_q;
          end
          state_d = S_DONE;
        end
        S_DONE: state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase

      busy_d = (state_d == S_PREP) || (state_d == S_RUN) || (state_d == S_FIX);
      done_d = (state_d == S_DONE);
    end
  end

  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.hi          = hi_q;
  assign bus.lo          = lo_q;
  assign bus.div_by_zero = dbz_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed plan cases plus randomized ops
// against an arithmetic reference model.
module tb_muldiv_unit;

  logic clk;
  logic rst;
  int   tests;
  int   failed;

  muldiv_unit_if #(.XLEN(32)) bus ();

  muldiv_unit #(.XLEN(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] mhi, output logic [31:0] mlo, output logic mdz);
    longint      sp;
    logic [63:0] up;
    int          sq;
    int          sr;
    mdz = 1'b0;
    mhi = '0;
    mlo = '0;
    case (op)
      2'b00: begin
        sp = longint'($signed(a)) * longint'($signed(b));
        {mhi, mlo} = sp;
      end
      2'b01: begin
        up = {32'd0, a} * {32'd0, b};
        {mhi, mlo} = up;
      end
      2'b10: begin
        if (b == 32'd0) begin
          mlo = 32'hFFFFFFFF; mhi = a; mdz = 1'b1;
        end else if (a == 32'h80000000 && b == 32'hFFFFFFFF) begin
          mlo = 32'h80000000; mhi = 32'd0;
        end else begin
          sq = $signed(a) / $signed(b);
          sr = $signed(a) % $signed(b);
          mlo = sq; mhi = sr;
        end
      end
      default: begin
        if (b == 32'd0) begin
          mlo = 32'hFFFFFFFF; mhi = a; mdz = 1'b1;
        end else begin
          mlo = a / b; mhi = a % b;
        end
      end
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Returns in the DONE cycle (or after a timeout, with done_cyc = -1).
  task automatic do_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                       input int hold_at, input int hold_len, input int poke_at,
                       output int done_cyc, output int busy_cnt);
    int cyc;
    bus.op = op; bus.src_a = a; bus.src_b = b; bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    cyc = 1; done_cyc = -1; busy_cnt = 0;
    while (done_cyc < 0 && cyc < 200) begin
      if (bus.done) done_cyc = cyc;
      else begin
        if (bus.busy) busy_cnt++;
        bus.hold = (hold_len > 0 && cyc >= hold_at && cyc < hold_at + hold_len);
        if (cyc == poke_at) begin
          bus.start = 1'b1; bus.op = ~op; bus.src_a = ~a; bus.src_b = b ^ 32'h5;
          bus.hi_we = 1'b1; bus.lo_we = 1'b1; bus.wdata = 32'hDEADBEEF;
        end else begin
          bus.start = 1'b0; bus.hi_we = 1'b0; bus.lo_we = 1'b0;
        end
        tick();
        cyc++;
      end
    end
    bus.hold = 1'b0; bus.start = 1'b0; bus.hi_we = 1'b0; bus.lo_we = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.start = 1'b1; bus.op = 2'b01; bus.src_a = 32'd5; bus.src_b = 32'd6;
    repeat (3) tick();
    tests++; if (bus.busy !== 1'b0) begin failed++; $display("FAIL reset_busy got=%b exp=0", bus.busy); end
    tests++; if (bus.done !== 1'b0) begin failed++; $display("FAIL reset_done got=%b exp=0", bus.done); end
    tests++; if (bus.hi !== 32'd0) begin failed++; $display("FAIL reset_hi got=%h exp=0", bus.hi); end
    tests++; if (bus.lo !== 32'd0) begin failed++; $display("FAIL reset_lo got=%h exp=0", bus.lo); end
    tests++; if (bus.div_by_zero !== 1'b0) begin failed++; $display("FAIL reset_dbz got=%b exp=0", bus.div_by_zero); end
    bus.start = 1'b0;
    rst = 1'b0;
    tick();
  endtask

  task automatic test_directed();
    logic [1:0]  t_op  [5] = '{2'b00, 2'b01, 2'b10, 2'b10, 2'b11};
    logic [31:0] t_a   [5] = '{32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFF9, 32'h80000000, 32'd100};
    logic [31:0] t_b   [5] = '{32'd7, 32'hFFFFFFFF, 32'd2, 32'hFFFFFFFF, 32'd0};
    logic [31:0] t_hi  [5] = '{32'hFFFFFFFF, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'd0, 32'h64};
    logic [31:0] t_lo  [5] = '{32'hFFFFFFEB, 32'h00000001, 32'hFFFFFFFD, 32'h80000000, 32'hFFFFFFFF};
    logic        t_dz  [5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    int dc, bc;
    for (int i = 0; i < 5; i++) begin
      do_op(t_op[i], t_a[i], t_b[i], -1, 0, -1, dc, bc);
      tests++; if (dc !== 35) begin failed++; $display("FAIL dir%0d_latency got=%0d exp=35", i, dc); end
      tests++; if (bc !== 34) begin failed++; $display("FAIL dir%0d_busy_cycles got=%0d exp=34", i, bc); end
      tests++; if (bus.hi !== t_hi[i]) begin failed++; $display("FAIL dir%0d_hi got=%h exp=%h", i, bus.hi, t_hi[i]); end
      tests++; if (bus.lo !== t_lo[i]) begin failed++; $display("FAIL dir%0d_lo got=%h exp=%h", i, bus.lo, t_lo[i]); end
      tests++; if (bus.div_by_zero !== t_dz[i]) begin failed++; $display("FAIL dir%0d_dbz got=%b exp=%b", i, bus.div_by_zero, t_dz[i]); end
      tick();
    end
  endtask

  task automatic test_dbz_clear();
    int cyc;
    bus.op = 2'b01; bus.src_a = 32'd2; bus.src_b = 32'd3; bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    tests++; if (bus.div_by_zero !== 1'b0) begin failed++; $display("FAIL dbz_clear got=%b exp=0", bus.div_by_zero); end
    cyc = 1;
    while (!bus.done && cyc < 200) begin tick(); cyc++; end
    tests++; if (bus.lo !== 32'd6) begin failed++; $display("FAIL dbz_clear_lo got=%h exp=6", bus.lo); end
    tick();
  endtask

  task automatic test_random();
    logic [1:0]  op;
    logic [31:0] a, b, ehi, elo;
    logic        edz;
    int dc, bc;
    for (int i = 0; i < 30; i++) begin
      op = 2'($urandom_range(0, 3));
      a  = ($urandom_range(0, 7) == 0) ? 32'h80000000 : $urandom;
      case ($urandom_range(0, 7))
        0: b = 32'd0;
        1: b = 32'hFFFFFFFF;
        2: b = 32'($urandom_range(1, 15));
        default: b = $urandom;
      endcase
      model(op, a, b, ehi, elo, edz);
      do_op(op, a, b, -1, 0, -1, dc, bc);
      tests++; if (dc !== 35) begin failed++; $display("FAIL rnd%0d_latency got=%0d exp=35", i, dc); end
      tests++; if (bus.hi !== ehi) begin failed++; $display("FAIL rnd%0d_hi op=%0d a=%h b=%h got=%h exp=%h", i, op, a, b, bus.hi, ehi); end
      tests++; if (bus.lo !== elo) begin failed++; $display("FAIL rnd%0d_lo op=%0d a=%h b=%h got=%h exp=%h", i, op, a, b, bus.lo, elo); end
      tests++; if (bus.div_by_zero !== edz) begin failed++; $display("FAIL rnd%0d_dbz got=%b exp=%b", i, bus.div_by_zero, edz); end
      tick();
    end
  endtask

  task automatic test_hold();
    logic [31:0] a, b, ehi, elo;
    logic        edz;
    int dc, bc;
    a = $urandom; b = $urandom;
    model(2'b00, a, b, ehi, elo, edz);
    do_op(2'b00, a, b, 10, 5, -1, dc, bc);
    tests++; if (dc !== 40) begin failed++; $display("FAIL hold_latency got=%0d exp=40", dc); end
    tests++; if (bc !== 39) begin failed++; $display("FAIL hold_busy_cycles got=%0d exp=39", bc); end
    tests++; if (bus.hi !== ehi || bus.lo !== elo) begin failed++; $display("FAIL hold_result got=%h_%h exp=%h_%h", bus.hi, bus.lo, ehi, elo); end
    bus.hold = 1'b1;
    bus.hi_we = 1'b1; bus.wdata = 32'h0BADF00D;
    for (int k = 0; k < 3; k++) begin
      tick();
      tests++; if (bus.done !== 1'b1) begin failed++; $display("FAIL hold_done_%0d got=%b exp=1", k, bus.done); end
    end
    tests++; if (bus.hi !== ehi) begin failed++; $display("FAIL hold_blocks_write got=%h exp=%h", bus.hi, ehi); end
    bus.hold = 1'b0; bus.hi_we = 1'b0;
    tick();
    tests++; if (bus.done !== 1'b0) begin failed++; $display("FAIL hold_release_done got=%b exp=0", bus.done); end
  endtask

  task automatic test_reset_mid();
    int seen;
    bus.op = 2'b01; bus.src_a = 32'h12345678; bus.src_b = 32'h9ABCDEF0; bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    repeat (11) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tests++; if (bus.busy !== 1'b0) begin failed++; $display("FAIL rstmid_busy got=%b exp=0", bus.busy); end
    tests++; if (bus.hi !== 32'd0 || bus.lo !== 32'd0) begin failed++; $display("FAIL rstmid_hilo got=%h_%h exp=0_0", bus.hi, bus.lo); end
    seen = 0;
    for (int k = 0; k < 45; k++) begin
      if (bus.done || bus.busy) seen++;
      tick();
    end
    tests++; if (seen !== 0) begin failed++; $display("FAIL rstmid_no_done got=%0d active cycles exp=0", seen); end
  endtask

  task automatic test_ignored_while_busy();
    logic [31:0] a, b, ehi, elo;
    logic        edz;
    int dc, bc;
    a = $urandom; b = $urandom;
    model(2'b01, a, b, ehi, elo, edz);
    do_op(2'b01, a, b, -1, 0, 5, dc, bc);
    tests++; if (dc !== 35) begin failed++; $display("FAIL busy_poke_latency got=%0d exp=35", dc); end
    tests++; if (bus.hi !== ehi || bus.lo !== elo) begin failed++; $display("FAIL busy_poke_result got=%h_%h exp=%h_%h", bus.hi, bus.lo, ehi, elo); end
    tick();
    tests++; if (bus.busy !== 1'b0) begin failed++; $display("FAIL busy_poke_no_second_op got=%b exp=0", bus.busy); end
  endtask

  task automatic test_mthi_mtlo();
    logic [31:0] a, b, ehi, elo;
    logic        edz;
    int dc, bc;
    bus.hi_we = 1'b1; bus.wdata = 32'hCAFEF00D;
    tick();
    bus.hi_we = 1'b0;
    tests++; if (bus.hi !== 32'hCAFEF00D) begin failed++; $display("FAIL mthi_idle got=%h exp=cafef00d", bus.hi); end
    bus.lo_we = 1'b1; bus.wdata = 32'h0BADC0DE;
    tick();
    bus.lo_we = 1'b0;
    tests++; if (bus.lo !== 32'h0BADC0DE || bus.hi !== 32'hCAFEF00D) begin failed++; $display("FAIL mtlo_idle got=%h_%h exp=cafef00d_0badc0de", bus.hi, bus.lo); end
    a = $urandom; b = 32'($urandom_range(1, 1000));
    model(2'b11, a, b, ehi, elo, edz);
    bus.hi_we = 1'b1; bus.lo_we = 1'b1; bus.wdata = 32'h11111111;
    do_op(2'b11, a, b, -1, 0, -1, dc, bc);
    tests++; if (bus.hi !== ehi || bus.lo !== elo) begin failed++; $display("FAIL mt_with_start got=%h_%h exp=%h_%h", bus.hi, bus.lo, ehi, elo); end
    bus.lo_we = 1'b1; bus.wdata = 32'h12345678;
    tick();
    bus.lo_we = 1'b0;
    tests++; if (bus.lo !== 32'h12345678 || bus.hi !== ehi) begin failed++; $display("FAIL mt_in_done got=%h_%h exp=%h_12345678", bus.hi, bus.lo, ehi); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] ehi, elo;
    logic        edz;
    int dc, bc;
    do_op(2'b00, 32'd1000, 32'hFFFFFFF0, -1, 0, -1, dc, bc);
    bus.op = 2'b10; bus.src_a = 32'd12345; bus.src_b = 32'hFFFFFFF9; bus.start = 1'b1;
    tick();
    tests++; if (bus.busy !== 1'b0) begin failed++; $display("FAIL b2b_start_in_done got=%b exp=0", bus.busy); end
    model(2'b10, 32'd12345, 32'hFFFFFFF9, ehi, elo, edz);
    do_op(2'b10, 32'd12345, 32'hFFFFFFF9, -1, 0, -1, dc, bc);
    tests++; if (dc !== 35) begin failed++; $display("FAIL b2b_latency got=%0d exp=35", dc); end
    tests++; if (bus.hi !== ehi || bus.lo !== elo) begin failed++; $display("FAIL b2b_result got=%h_%h exp=%h_%h", bus.hi, bus.lo, ehi, elo); end
    tick();
  endtask

  initial begin
    tests = 0; failed = 0;
    rst = 1'b1;
    bus.start = 1'b0; bus.op = '0; bus.src_a = '0; bus.src_b = '0;
    bus.hold = 1'b0; bus.hi_we = 1'b0; bus.lo_we = 1'b0; bus.wdata = '0;
    tick();
    test_reset();
    test_directed();
    test_dbz_clear();
    test_random();
    test_hold();
    test_reset_mid();
    test_ignored_while_busy();
    test_mthi_mtlo();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog expired tests=%0d", tests);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Iterative 32-bit multiply/divide unit in the execute stage, beside the combinational ALU. It takes MULT/MULTU/DIV/DIVU out of the single-cycle ALU path and produces the 64-bit result into architectural HI/LO registers over a fixed multi-cycle latency. It uses a start/busy/done handshake that the pipeline control uses to stall MFHI/MFLO consumers. A `hold` input freezes the unit while the pipeline is stalled, for example on a cache miss.

## Interface
- `XLEN`, 32, operand and HI/LO width. Only 32 is supported.
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  launch the operation in `op` on `src_a`/`src_b`.
- `op`  in  2  operation: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
- `src_a`  in  32  multiplicand or dividend (rs).
- `src_b`  in  32  multiplier or divisor (rt).
- `hold`  in  1  freeze all state while high.
- `hi_we`, `lo_we`  in  1 each  MTHI/MTLO write enables.
- `wdata`  in  32  MTHI/MTLO data.
- `busy`  out  1  operation in progress (PREP, RUN or FIX).
- `done`  out  1  one-cycle pulse; HI/LO hold the new result.
- `hi`, `lo`  out  32 each  architectural HI/LO registers.
- `div_by_zero`  out  1  last completed DIV/DIVU had `src_b == 0`; cleared by the next accepted start.

## Operation
- **Reset values:** state IDLE, counter 0; `hi`=`lo`=0; `busy`=`done`=`div_by_zero`=0. A reset asserted mid-operation aborts it, and no result is written.
- **States:** IDLE → PREP → RUN (32 iterations) → FIX → DONE → IDLE.
- **IDLE:**
  - `start`=1 and `hold`=0 latches `op`, `src_a`, `src_b` and goes to PREP.
  - `start` is ignored in every other state.
- **PREP:**
  - For signed ops, record the operand signs and replace each operand with its magnitude (two's complement negate when negative).
  - Clear the 64-bit accumulator/remainder and set the counter to 0.
- **RUN, multiply:** shift-add, one multiplier bit per cycle, LSB first.
- **RUN, divide:** restoring division, one quotient bit per cycle, MSB first. The counter increments each cycle; the cycle on which it reaches 31 exits to FIX.
- **FIX, multiply:** negate the 64-bit product if the operand signs differ (MULT only).
- **FIX, divide:**
  - Quotient is negated if the signs differ; remainder takes the dividend's sign. Quotient truncates toward zero.
  - `lo` = quotient, `hi` = remainder, written on the FIX→DONE edge.
  - Multiply writes `{hi,lo}` = 64-bit product on the same edge.
- **Divide by zero (DIV or DIVU):**
  - `lo`=32'hFFFFFFFF, `hi`=`src_a` as latched, regardless of sign; `div_by_zero`=1.
  - Latency is unchanged.
- **Overflow:** DIV 32'h80000000 / 32'hFFFFFFFF gives `lo`=32'h80000000, `hi`=0, with no flag.
- **DONE:** `done`=1 and `busy`=0 for one cycle, then IDLE.
- **MTHI/MTLO writes:**
  - `hi_we`/`lo_we` write `wdata` only when `busy`=0 and `hold`=0; they are ignored while busy.
  - A write on the same edge as an accepted start is performed; the later result overwrites it.
  - A write in the DONE cycle overwrites the just-produced value.
- **hold=1:** state, counter, datapath registers, HI/LO and `done` are all frozen.
  - `done` stays high for as long as `hold` holds the unit in DONE.
  - `start` and writes are not accepted while `hold`=1.

## Timing
- Edge E0 accepts `start`.
- PREP is the cycle after E0.
- RUN occupies the 32 edges E2–E33.
- FIX follows; E34 writes HI/LO.
- `done`=1 in the cycle after E34.
- Result is readable 35 cycles after E0. Every cycle of `hold`=1 adds one cycle.
- `busy` is high in the cycles after E0 through E34 (PREP, RUN, FIX).
- Next start is accepted earliest at E36; DONE is a mandatory one-cycle bubble.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Test plan
- **MULT:** `src_a`=32'hFFFFFFFD (−3), `src_b`=7 → `hi`=32'hFFFFFFFF, `lo`=32'hFFFFFFEB. `done` pulses exactly 35 cycles after start; `busy` is high for 34 cycles.
- **MULTU:** 32'hFFFFFFFF × 32'hFFFFFFFF → `hi`=32'hFFFFFFFE, `lo`=32'h00000001.
- **DIV and DIVU:**
  - DIV −7 / 2 → `lo`=32'hFFFFFFFD, `hi`=32'hFFFFFFFF.
  - DIV 32'h80000000 / −1 → `lo`=32'h80000000, `hi`=0.
  - DIVU 100 / 0 → `lo`=32'hFFFFFFFF, `hi`=32'h64, `div_by_zero`=1. The next accepted start clears `div_by_zero`.
- **Hold:** `hold`=1 for 5 cycles mid-RUN → `done` arrives at cycle 40 with the correct product. `hold` held in DONE keeps `done`=1.
- **Reset mid-operation:** `rst` at cycle 10 of RUN → next cycle `busy`=0, `hi`=`lo`=0, no `done`. A `start` issued while busy is ignored and does not change the result.
- **MTHI/MTLO:**
  - `hi_we` with `wdata`=32'hCAFEF00D while idle → `hi` updates on the next edge.
  - The same write while busy is dropped.
  - A write coincident with start is overwritten by the result.
